wb_stage_pipe: RTL and testbench
================================

WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values are 32 and 64.
REQ-002 Parameter NREG, default 32, register count; RW = $clog2(NREG).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Ports in_valid (input, 1) and in_ready (output, 1): upstream handshake; a transfer occurs when both are high at a clock edge.
REQ-006 Port in_sel, input, 3 bits: writeback source. 0=alu, 1=load, 2=return_addr, 3=imm (LUI), 4=pc_offset (AUIPC).
REQ-007 Ports in_alu, in_mem, in_ret, in_imm, in_pcoff: inputs, XLEN each; source operands. in_alu[1:0] is also the load byte offset.
REQ-008 Port in_funct3, input, 3 bits: load type. 000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU.
REQ-009 Port in_rd, input, RW bits: destination register index.
REQ-010 Port hold, input, 1 bit: downstream stall.
REQ-011 Ports rf_we (1), rf_waddr (RW), rf_wdata (XLEN): outputs; register-file write port.
REQ-012 Ports fwd_valid (1), fwd_rd (RW), fwd_data (XLEN): outputs; forwarding of the held entry.
REQ-013 Ports exc_misalign (1), exc_illegal (1), exc_addr (XLEN): outputs; exception report.
REQ-014 Port instret, output, 64 bits: retired-instruction counter.

Function
REQ-015 One-entry pipeline register (valid_q plus payload) shall sit between the input handshake and the write port.
REQ-016 in_ready shall equal !valid_q | !hold, combinationally.
REQ-017 On a transfer, the register shall capture the selected, extended result, rd, sel, funct3, in_alu[1:0] and in_alu; on any other edge it holds.
REQ-018 A transfer that coincides with retirement of the held entry shall replace that entry in the same edge, giving zero-bubble throughput.
REQ-019 Load extension operates on the XLEN word in_mem, shifted right by 8*offset:
- LB/LH sign-extend bits 7/15.
- LBU/LHU zero-extend.
- LW passes 32 bits, sign-extended to XLEN.
REQ-020 Misalignment: LH/LHU with offset[0]=1, or LW with offset!=0, is misaligned.
REQ-021 Illegal: sel 5..7, or sel=1 with funct3 in {011,110,111}, is illegal.
REQ-022 Retire event = valid_q & !hold; valid_q shall clear at that edge unless a new transfer occurs.
REQ-023 rf_we shall be 1 only on a retire event with no exception and rf_waddr!=0; rf_waddr and rf_wdata come from the register.
REQ-024 exc_misalign and exc_illegal shall each pulse for exactly the retire cycle of the faulting entry; exc_addr = captured in_alu (misalign) or 0 (illegal); no register write occurs.
REQ-025 When illegal and misaligned both apply, only exc_illegal shall assert.
REQ-026 fwd_valid shall be valid_q & no exception & rd!=0, including while hold=1; fwd_rd and fwd_data mirror the register.
REQ-027 instret shall increment by 1 on each retire event without exception, and wrap from 2^64-1 to 0.
REQ-028 While hold=1 with valid_q=1, outputs shall be stable, rf_we=0, and instret shall not change.

Reset
REQ-029 While rst_n=0, asynchronously: valid_q=0, all outputs except in_ready = 0, instret = 0, in_ready = 1.
REQ-030 Reset asserted mid-hold shall discard the held entry with no write and no exception pulse; the first edge after deassertion may accept a transfer.

Verification
REQ-031 LB: sel=1, funct3=000, in_alu=0x1003, in_mem=0x80FF_1234, rd=5, hold=0 -> next cycle rf_we=1, waddr=5, wdata=0xFFFF_FF80; instret=1.
REQ-032 LHU: offset 2, in_mem=0xBEEF_0000 -> wdata=0x0000_BEEF. LW with in_alu=0x1002 -> exc_misalign=1 for 1 cycle, exc_addr=0x1002, rf_we=0, instret unchanged.
REQ-033 Back-to-back: three transfers on consecutive cycles with sel=3 and imm values A, B, C, hold=0 -> three consecutive rf_we cycles writing A, B, C, with in_ready=1 throughout.
REQ-034 Hold: entry valid, hold=1 for 4 cycles -> in_ready=0, fwd_valid=1, rf_we=0, outputs stable; on hold release, one write and instret +1.
REQ-035 rd=0 with sel=0 -> rf_we=0, fwd_valid=0, instret still +1. sel=6 -> exc_illegal pulse, exc_addr=0.
REQ-036 Preload instret to 2^64-1 through the testbench's force mechanism, retire one instruction -> instret=0. rst_n low mid-hold -> all outputs 0 at once and in_ready=1.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// Writeback stage: one-entry pipeline register between the upstream
// handshake and the register-file write port, with load extension,
// exception reporting and a retired-instruction counter.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        upstream handshake
//   in_sel, in_funct3, in_rd   writeback source, load type, destination
//   in_alu .. in_pcoff         source operands (in_alu[1:0] = load offset)
//   hold                       downstream stall
//   rf_we/rf_waddr/rf_wdata    register-file write port
//   fwd_valid/fwd_rd/fwd_data  forwarding of the held entry
//   exc_misalign/exc_illegal   exception pulses, exc_addr = faulting addr
//   instret                    retired-instruction counter
module wb_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_mem,
    input  logic [XLEN-1:0] in_ret,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pcoff,
    input  logic [2:0]      in_funct3,
    input  logic [RW-1:0]   in_rd,
    input  logic            hold,
    output logic            rf_we,
    output logic [RW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd_valid,
    output logic [RW-1:0]   fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            exc_misalign,
    output logic            exc_illegal,
    output logic [XLEN-1:0] exc_addr,
    output logic [63:0]     instret
);

    logic            valid_q;
    logic [XLEN-1:0] res_q;
    logic [RW-1:0]   rd_q;
    logic [2:0]      sel_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] alu_q;
    logic [63:0]     instret_q;

    logic            xfer;
    logic            retire;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] result;
    logic            is_load_q;
    logic            illegal_q;
    logic            misal_q;
    logic            exc_q;

    assign in_ready = !valid_q || !hold;
    assign xfer     = in_valid && in_ready;
    assign retire   = valid_q && !hold;

    // Byte offset selects the addressed lane of the memory word.
    assign shifted = in_mem >> {in_alu[1:0], 3'b000};

    always_comb begin
        load_val = '0;
        case (in_funct3)
            3'b000:  load_val = XLEN'($signed(shifted[7:0]));
            3'b001:  load_val = XLEN'($signed(shifted[15:0]));
            3'b010:  load_val = XLEN'($signed(shifted[31:0]));
            3'b100:  load_val = XLEN'(shifted[7:0]);
            3'b101:  load_val = XLEN'(shifted[15:0]);
            default: load_val = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (in_sel)
            3'd0:    result = in_alu;
            3'd1:    result = load_val;
            3'd2:    result = in_ret;
            3'd3:    result = in_imm;
            3'd4:    result = in_pcoff;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            sel_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            alu_q   <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            res_q   <= result;
            rd_q    <= in_rd;
            sel_q   <= in_sel;
            f3_q    <= in_funct3;
            off_q   <= in_alu[1:0];
            alu_q   <= in_alu;
        end else if (retire) begin
            valid_q <= 1'b0;
        end
    end

    // Exception classification is derived from the captured fields;
    // illegal takes priority so misalign is masked by it.
    assign is_load_q = (sel_q == 3'd1);
    assign illegal_q = (sel_q > 3'd4) ||
                       (is_load_q && (f3_q == 3'b011 || f3_q[2:1] == 2'b11));
    assign misal_q   = is_load_q && !illegal_q &&
                       ((f3_q[1:0] == 2'b01 && off_q[0]) ||
                        (f3_q == 3'b010 && off_q != 2'b00));
    assign exc_q     = illegal_q || misal_q;

    assign rf_we        = retire && !exc_q && (rd_q != '0);
    assign rf_waddr     = rd_q;
    assign rf_wdata     = res_q;
    assign fwd_valid    = valid_q && !exc_q && (rd_q != '0);
    assign fwd_rd       = rd_q;
    assign fwd_data     = res_q;
    assign exc_misalign = retire && misal_q;
    assign exc_illegal  = retire && illegal_q;
    assign exc_addr     = exc_misalign ? alu_q : '0;
    assign instret      = instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire && !exc_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Testbench for wb_stage_pipe: directed vector table, randomized
// transfers against a reference model, and multi-cycle sequences.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [31:0] in_alu, in_mem, in_ret, in_imm, in_pcoff;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        exc_misalign, exc_illegal;
    logic [31:0] exc_addr;
    logic [63:0] instret;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_instret = '0;

    always #5 clk = ~clk;

    wb_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem),
        .in_ret(in_ret), .in_imm(in_imm), .in_pcoff(in_pcoff),
        .in_funct3(in_funct3), .in_rd(in_rd), .hold(hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .exc_misalign(exc_misalign), .exc_illegal(exc_illegal),
        .exc_addr(exc_addr), .instret(instret)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu, mem, ret, imm, pcoff;
        logic [4:0]  rd;
    } in_t;

    typedef struct {
        logic        we, fwd, mis, ill;
        logic [31:0] data, addr;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: arithmetic on the specification's rules.
    function automatic out_t model(input in_t x);
        out_t        o;
        longint      off, sh, v;
        longint unsigned m;
        off = longint'(x.alu) % 4;
        m   = x.mem;
        sh  = longint'(m >> (8 * off));
        o.ill = (x.sel >= 5) ||
                (x.sel == 1 && (x.f3 == 3 || x.f3 == 6 || x.f3 == 7));
        o.mis = !o.ill && x.sel == 1 &&
                (((x.f3 == 1 || x.f3 == 5) && (off % 2) == 1) ||
                 (x.f3 == 2 && off != 0));
        v = 0;
        case (x.sel)
            3'd0: v = longint'(x.alu);
            3'd1: begin
                case (x.f3)
                    3'd0: begin v = sh % 256; if (v >= 128) v = v - 256; end
                    3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
                    3'd2: v = sh % 64'h1_0000_0000;
                    3'd4: v = sh % 256;
                    3'd5: v = sh % 65536;
                    default: v = 0;
                endcase
            end
            3'd2: v = longint'(x.ret);
            3'd3: v = longint'(x.imm);
            3'd4: v = longint'(x.pcoff);
            default: v = 0;
        endcase
        o.data = v[31:0];
        o.we   = !o.ill && !o.mis && x.rd != 0;
        o.fwd  = o.we;
        o.addr = o.mis ? x.alu : 32'h0;
        return o;
    endfunction

    task automatic drive(input in_t x);
        in_valid  = 1'b1;
        in_sel    = x.sel;
        in_funct3 = x.f3;
        in_alu    = x.alu;
        in_mem    = x.mem;
        in_ret    = x.ret;
        in_imm    = x.imm;
        in_pcoff  = x.pcoff;
        in_rd     = x.rd;
    endtask

    task automatic apply(input in_t x, input out_t e, input string tag);
        @(negedge clk);
        hold = 1'b0;
        drive(x);
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, ".rf_we"}, 64'(rf_we), 64'(e.we));
        chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(e.fwd));
        chk({tag, ".exc_misalign"}, 64'(exc_misalign), 64'(e.mis));
        chk({tag, ".exc_illegal"}, 64'(exc_illegal), 64'(e.ill));
        if (e.we) begin
            chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(x.rd));
            chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(e.data));
        end
        if (e.fwd)
            chk({tag, ".fwd_data"}, 64'(fwd_data), 64'(e.data));
        if (e.mis || e.ill)
            chk({tag, ".exc_addr"}, 64'(exc_addr), 64'(e.addr));
        if (!(e.mis || e.ill))
            exp_instret = exp_instret + 64'd1;
        @(posedge clk);
        #1;
        chk({tag, ".instret"}, instret, exp_instret);
        chk({tag, ".idle_we"}, 64'(rf_we), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rf_we"}, 64'(rf_we), 64'd0);
        chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'd0);
        chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'd0);
        chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'd0);
        chk({tag, ".fwd_rd"}, 64'(fwd_rd), 64'd0);
        chk({tag, ".fwd_data"}, 64'(fwd_data), 64'd0);
        chk({tag, ".exc_mis"}, 64'(exc_misalign), 64'd0);
        chk({tag, ".exc_ill"}, 64'(exc_illegal), 64'd0);
        chk({tag, ".exc_addr"}, 64'(exc_addr), 64'd0);
        chk({tag, ".instret"}, instret, 64'd0);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    endtask

    function automatic in_t mk(input logic [2:0] sel, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [31:0] val, input logic [4:0] rd);
        in_t x;
        x.sel = sel; x.f3 = f3; x.alu = alu; x.mem = mem;
        x.ret = val; x.imm = val; x.pcoff = val; x.rd = rd;
        return x;
    endfunction

    function automatic out_t mo(input logic we, input logic mis,
                                input logic ill, input logic [31:0] data,
                                input logic [31:0] addr);
        out_t o;
        o.we = we; o.fwd = we; o.mis = mis; o.ill = ill;
        o.data = data; o.addr = addr;
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[12];
        in_t         x;
        out_t        e;
        logic [31:0] bb[3];
        logic [63:0] snap;

        rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
        in_sel = '0; in_funct3 = '0; in_rd = '0;
        in_alu = '0; in_mem = '0; in_ret = '0; in_imm = '0; in_pcoff = '0;

        tbl[0]  = '{mk(1, 0, 32'h1003, 32'h80FF_1234, 0, 5),
                    mo(1, 0, 0, 32'hFFFF_FF80, 0)};
        tbl[1]  = '{mk(1, 5, 32'h2002, 32'hBEEF_0000, 0, 6),
                    mo(1, 0, 0, 32'h0000_BEEF, 0)};
        tbl[2]  = '{mk(1, 2, 32'h1002, 32'h1111_2222, 0, 7),
                    mo(0, 1, 0, 0, 32'h1002)};
        tbl[3]  = '{mk(0, 0, 32'h1234, 0, 0, 0),
                    mo(0, 0, 0, 32'h1234, 0)};
        tbl[4]  = '{mk(6, 2, 32'h0005, 0, 0, 3),
                    mo(0, 0, 1, 0, 0)};
        tbl[5]  = '{mk(1, 1, 32'h0002, 32'h9ABC_0000, 0, 8),
                    mo(1, 0, 0, 32'hFFFF_9ABC, 0)};
        tbl[6]  = '{mk(1, 4, 32'h0001, 32'h0000_F000, 0, 9),
                    mo(1, 0, 0, 32'h0000_00F0, 0)};
        tbl[7]  = '{mk(2, 0, 0, 0, 32'h8000_0004, 1),
                    mo(1, 0, 0, 32'h8000_0004, 0)};
        tbl[8]  = '{mk(4, 0, 0, 0, 32'h1234_5000, 31),
                    mo(1, 0, 0, 32'h1234_5000, 0)};
        tbl[9]  = '{mk(1, 3, 32'h0040, 32'h1, 0, 4),
                    mo(0, 0, 1, 0, 0)};
        tbl[10] = '{mk(1, 1, 32'h0000_3001, 32'h1, 0, 4),
                    mo(0, 1, 0, 0, 32'h0000_3001)};
        tbl[11] = '{mk(1, 2, 32'h0000_0100, 32'hDEAD_BEEF, 0, 10),
                    mo(1, 0, 0, 32'hDEAD_BEEF, 0)};

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            apply(tbl[i].i, tbl[i].o, $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            x.sel   = ($urandom % 2 == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            x.f3    = 3'($urandom);
            x.alu   = $urandom;
            x.mem   = $urandom;
            x.ret   = $urandom;
            x.imm   = $urandom;
            x.pcoff = $urandom;
            x.rd    = 5'($urandom_range(0, 31));
            e = model(x);
            apply(x, e, $sformatf("rnd%0d", i));
        end

        // Three transfers on consecutive edges.
        bb[0] = 32'hA0A0_0001; bb[1] = 32'hB0B0_0002; bb[2] = 32'hC0C0_0003;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("b2b%0d.rf_we", i), 64'(rf_we), 64'd1);
                chk($sformatf("b2b%0d.wdata", i), 64'(rf_wdata), 64'(bb[i-1]));
            end
            if (i < 3) begin
                drive(mk(3, 0, 0, 0, bb[i], 5'(12 + i)));
                #1;
                chk($sformatf("b2b%0d.in_ready", i), 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
        end
        exp_instret = exp_instret + 64'd3;
        @(posedge clk);
        #1;
        chk("b2b.instret", instret, exp_instret);

        // Hold an entry for four cycles while offering a rival transfer.
        @(negedge clk);
        drive(mk(0, 0, 32'h0000_CAFE, 0, 0, 7));
        @(posedge clk);
        #1;
        hold = 1'b1;
        drive(mk(0, 0, 32'h0000_0BAD, 0, 0, 9));
        snap = instret;
        repeat (4) begin
            @(negedge clk);
            chk("hold.in_ready", 64'(in_ready), 64'd0);
            chk("hold.fwd_valid", 64'(fwd_valid), 64'd1);
            chk("hold.fwd_rd", 64'(fwd_rd), 64'd7);
            chk("hold.fwd_data", 64'(fwd_data), 64'h0000_CAFE);
            chk("hold.rf_we", 64'(rf_we), 64'd0);
            chk("hold.rf_wdata", 64'(rf_wdata), 64'h0000_CAFE);
            chk("hold.instret", instret, snap);
        end
        @(negedge clk);
        hold = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("release.rf_we", 64'(rf_we), 64'd1);
        chk("release.rf_waddr", 64'(rf_waddr), 64'd7);
        chk("release.rf_wdata", 64'(rf_wdata), 64'h0000_CAFE);
        exp_instret = exp_instret + 64'd1;
        @(posedge clk);
        #1;
        chk("release.instret", instret, exp_instret);

        // Counter wrap from all ones.
        @(negedge clk);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        chk("preload.instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        apply(mk(3, 0, 0, 0, 32'h5555_0000, 2),
              mo(1, 0, 0, 32'h5555_0000, 0), "wrap");

        // Reset in the middle of a hold.
        @(negedge clk);
        drive(mk(3, 0, 0, 0, 32'h7777_0000, 11));
        @(posedge clk);
        #1;
        hold = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midhold_rst");
        exp_instret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        hold = 1'b0;
        drive(mk(3, 0, 0, 0, 32'h1357_9BDF, 13));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst.rf_we", 64'(rf_we), 64'd1);
        chk("post_rst.rf_wdata", 64'(rf_wdata), 64'h1357_9BDF);
        exp_instret = exp_instret + 64'd1;
        @(posedge clk);
        #1;
        chk("post_rst.instret", instret, exp_instret);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
